instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the main opcode controller: accepts instruction descriptors (mnemonic code plus fields) over a valid/ready handshake.
- Assembles each into a 32-bit MIPS word and writes it sequentially into instruction memory.
- Used by the bench and boot path to load programs for the single-cycle core.
- Supports exactly the instruction set the core decodes: R-type add/sub/and/or/slt, addi, addiu, beq, j, lw, sw, lui, ori.

Parameters:
- ADDR_W, 10: instruction-memory word-address width. DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load session (honoured in IDLE and DONE only)
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready at a clk edge
- in_last  in  1  marks final descriptor of the session
- in_kind  in  4  mnemonic code (see Behaviour)
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_imm  in  16  immediate
- in_target  in  26  jump target
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- done  out  1  session complete
- err  out  1  sticky: an illegal in_kind was seen this session

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err=0, write pointer ptr=0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE --start--> LOAD.
  - LOAD --accept with in_last=1, or accept that makes ptr==DEPTH--> DONE.
  - DONE --start--> LOAD.
  - start is ignored while in LOAD.
  - Entering LOAD clears ptr, count, err and done.
- in_ready = (state==LOAD) and ptr<DEPTH. It is a combinational function of registered state only and never depends on in_valid.
- Accept, legal kind:
  - On the next edge: imem_we=1, imem_addr=ptr[ADDR_W-1:0], imem_wdata=encoded word, ptr+=1.
  - Latency is one cycle, accept edge to write strobe.
  - count increments on the cycle the strobe is high, so count lags ptr by at most 1.
- Accept, illegal kind (13..15): consumed, no write strobe, ptr unchanged, err<=1. An illegal kind with in_last=1 still moves the FSM to DONE.
- imem_we is high exactly one cycle per legal accept. Back-to-back accepts give back-to-back strobes with consecutive addresses.
- done=1 from the cycle after the final write (or final accept if illegal) until the next start or reset.
- Kind codes and encodings:
  - 0 ADD, funct 100000.
  - 1 SUB, funct 100010.
  - 2 AND, funct 100100.
  - 3 OR, funct 100101.
  - 4 SLT, funct 101010.
  - R-type word = {000000, rs, rt, rd, 00000, funct}.
  - 5 ADDI 001000; 6 ADDIU 001001; 7 BEQ 000100; 9 LW 100011; 10 SW 101011; 11 LUI 001111; 12 ORI 001101.
  - I-type word = {op, rs, rt, imm}. LUI forces rs=00000.
  - 8 J: word = {000010, target}.
  - Unused input fields are ignored.
- Boundary cases:
  - ptr reaching DEPTH forces DONE even without in_last; in_ready drops the same cycle.
  - No wrap-around; descriptors presented in DONE or IDLE are not accepted.
- Reset mid-session:
  - Any pending write strobe is cancelled (imem_we=0 on the reset cycle).
  - All state returns to reset values.
  - Memory contents already written are not touched.

Test Plan:
- Encoding check. start, then ADD rs=1 rt=2 rd=3 -> next cycle imem_we=1, addr=0, wdata=0x00221820. Then, on addresses 1..4:
  - ADDI rt=8 imm=0x0005 -> 0x20080005.
  - LUI rs=7 rt=1 imm=0x1234 -> 0x3C011234 (rs forced 0).
  - BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF.
  - J target=0x0000010 -> 0x08000010.
- Memory ops: LW rs=29 rt=9 imm=4 -> 0x8FA90004; SW same fields -> 0xAFA90004. Back-to-back accepts -> strobes on consecutive cycles and addresses.
- Illegal kind: start, in_kind=14 -> no imem_we, err=1 sticky, ptr stays 0. Next ADD writes addr 0. A new start clears err.
- Capacity: ADDR_W=2, start, 6 descriptors held valid without in_last -> exactly 4 writes (addr 0..3); in_ready=0 after the 4th accept; done=1, count=4; descriptors 5-6 not accepted.
- in_last and restart: 2 descriptors with in_last on the 2nd -> done=1, count=2, FSM in DONE. start -> done=0, next write at addr 0. start asserted in LOAD -> ignored, ptr continues.
- Reset mid-session: reset on the cycle after an accept -> imem_we=0, count=0, in_ready=0, state IDLE.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Descriptor handshake plus instruction-memory write port of the program loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              err;

    // Producer of descriptors (bench / boot path)
    modport master (
        output start, in_valid, in_last, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, done, err
    );

    // The loader itself
    modport slave (
        input  start, in_valid, in_last, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, imem_we, imem_addr, imem_wdata, count, done, err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Program loader: turns instruction descriptors into MIPS words and writes them
// to consecutive instruction-memory addresses, one write strobe per legal descriptor.
module instr_encoder_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_encoder_loader_if.slave  bus
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              in_ready;
    logic              accept;
    logic              legal;
    logic              restart;
    logic [ADDR_W:0]   ptr_inc;

    // Kinds 13..15 have no encoding in the core's instruction set
    function automatic logic kind_legal(input logic [3:0] kind);
        return kind <= 4'd12;
    endfunction

    function automatic logic [31:0] encode(input logic [3:0]  kind,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [15:0] imm,
                                           input logic [25:0] target);
        logic [5:0] funct;
        funct = 6'b100000;
        case (kind)
            4'd1:    funct = 6'b100010;
            4'd2:    funct = 6'b100100;
            4'd3:    funct = 6'b100101;
            4'd4:    funct = 6'b101010;
            default: funct = 6'b100000;
        endcase
        case (kind)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: return {6'b000000, rs, rt, rd, 5'b00000, funct};
            4'd5:    return {6'b001000, rs, rt, imm};
            4'd6:    return {6'b001001, rs, rt, imm};
            4'd7:    return {6'b000100, rs, rt, imm};
            4'd8:    return {6'b000010, target};
            4'd9:    return {6'b100011, rs, rt, imm};
            4'd10:   return {6'b101011, rs, rt, imm};
            4'd11:   return {6'b001111, 5'b00000, rt, imm};
            4'd12:   return {6'b001101, rs, rt, imm};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Ready depends only on registered state so it never combinationally follows in_valid
    assign in_ready = (state_q == S_LOAD) && (ptr_q < DEPTH_C);
    assign accept   = bus.in_valid && in_ready;
    assign legal    = kind_legal(bus.in_kind);
    assign restart  = bus.start && (state_q != S_LOAD);
    assign ptr_inc  = ptr_q + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: session ends on in_last or when the memory is full
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_LOAD;
            S_LOAD: if (accept && (bus.in_last || (legal && ptr_inc == DEPTH_C))) state_d = S_DONE;
            S_DONE: if (bus.start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next-state: write strobe, pointer, counters and flags
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        if (restart) begin
            ptr_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
        end else begin
            if (we_q) count_d = count_q + 1'b1;
            if (accept) begin
                if (legal) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q[ADDR_W-1:0];
                    wdata_d = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                                     bus.in_imm, bus.in_target);
                    ptr_d   = ptr_inc;
                end else begin
                    err_d = 1'b1;
                    // An illegal final descriptor has no write to wait for
                    if (state_d == S_DONE) done_d = 1'b1;
                end
            end
            // done rises once the final strobe has been issued
            if (we_q && state_q == S_DONE) done_d = 1'b1;
        end
    end

    // Datapath registers; reset also cancels any pending strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.count      = count_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for the program loader: a wide instance for encoding/session
// behaviour and a 4-word instance for the capacity limit.
module tb_instr_encoder_loader;
    logic clk;
    logic reset;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   exp_ptr;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] w;
        int          cyc;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    ent_t ea;
    ent_t eb;

    instr_encoder_loader_if #(.ADDR_W(10)) ifa ();
    instr_encoder_loader_if #(.ADDR_W(2))  ifb ();

    instr_encoder_loader #(.ADDR_W(10)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    instr_encoder_loader #(.ADDR_W(2))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop for each strobe of the wide instance
    always @(negedge clk) begin
        if (ifa.imem_we === 1'b1) begin
            if (qa.size() == 0) chk("unexpected_we_a", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("a_addr", 64'(ifa.imem_addr), 64'(ea.addr));
                chk("a_wdata", 64'(ifa.imem_wdata), 64'(ea.w));
                chk("a_strobe_cycle", 64'(cyc), 64'(ea.cyc));
            end
        end
    end

    // Scoreboard pop for each strobe of the small instance
    always @(negedge clk) begin
        if (ifb.imem_we === 1'b1) begin
            if (qb.size() == 0) chk("unexpected_we_b", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("b_addr", 64'(ifb.imem_addr), 64'(eb.addr));
                chk("b_wdata", 64'(ifb.imem_wdata), 64'(eb.w));
            end
        end
    end

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last, input logic is_legal, input logic [31:0] exp_w);
        ent_t e;
        bit   ok;
        @(negedge clk);
        ifa.in_kind   = k;
        ifa.in_rs     = rs;
        ifa.in_rt     = rt;
        ifa.in_rd     = rd;
        ifa.in_imm    = imm;
        ifa.in_target = tgt;
        ifa.in_last   = last;
        ifa.in_valid  = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ifa.in_ready === 1'b1) begin
                ok = 1'b1;
                if (is_legal) begin
                    e.addr = 10'(exp_ptr);
                    e.w    = exp_w;
                    e.cyc  = cyc + 1;
                    qa.push_back(e);
                    exp_ptr++;
                end
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else chk("accept_timeout", 0, 1);
    endtask

    task automatic idle_a();
        @(negedge clk);
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
    endtask

    task automatic start_a(input bit clr_ptr);
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        if (clr_ptr) exp_ptr = 0;
    endtask

    initial begin
        int acc;
        ent_t e;
        cyc = 0; vectors = 0; miscompares = 0; exp_ptr = 0;
        reset = 1'b1;
        ifa.start = 0; ifa.in_valid = 0; ifa.in_last = 0; ifa.in_kind = 0;
        ifa.in_rs = 0; ifa.in_rt = 0; ifa.in_rd = 0; ifa.in_imm = 0; ifa.in_target = 0;
        ifb.start = 0; ifb.in_valid = 0; ifb.in_last = 0; ifb.in_kind = 0;
        ifb.in_rs = 0; ifb.in_rt = 0; ifb.in_rd = 0; ifb.in_imm = 0; ifb.in_target = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values
        chk("rst_in_ready", 64'(ifa.in_ready), 0);
        chk("rst_we", 64'(ifa.imem_we), 0);
        chk("rst_addr", 64'(ifa.imem_addr), 0);
        chk("rst_wdata", 64'(ifa.imem_wdata), 0);
        chk("rst_count", 64'(ifa.count), 0);
        chk("rst_done", 64'(ifa.done), 0);
        chk("rst_err", 64'(ifa.err), 0);
        chk("rst_b_ready", 64'(ifb.in_ready), 0);

        // Descriptors in IDLE are not accepted
        @(negedge clk);
        ifa.in_valid = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", 64'(ifa.in_ready), 0);
        ifa.in_valid = 1'b0;

        // Encoding session, all back-to-back, unused fields non-zero
        start_a(1);
        chk("load_ready", 64'(ifa.in_ready), 1);
        send(4'd0,  5'd1,  5'd2, 5'd3,  16'h0000, 26'h0,       0, 1, 32'h00221820);
        send(4'd5,  5'd0,  5'd8, 5'd31, 16'h0005, 26'h3FFFFFF, 0, 1, 32'h20080005);
        send(4'd11, 5'd7,  5'd1, 5'd0,  16'h1234, 26'h0,       0, 1, 32'h3C011234);
        send(4'd7,  5'd1,  5'd2, 5'd0,  16'hFFFF, 26'h0,       0, 1, 32'h1022FFFF);
        send(4'd8,  5'd5,  5'd6, 5'd7,  16'hAAAA, 26'h0000010, 0, 1, 32'h08000010);
        send(4'd9,  5'd29, 5'd9, 5'd0,  16'h0004, 26'h0,       0, 1, 32'h8FA90004);
        send(4'd10, 5'd29, 5'd9, 5'd0,  16'h0004, 26'h0,       1, 1, 32'hAFA90004);
        idle_a();
        chk("enc_done_lag", 64'(ifa.done), 0);
        chk("enc_ready_off", 64'(ifa.in_ready), 0);
        chk("enc_count_lag", 64'(ifa.count), 6);
        @(negedge clk);
        chk("enc_done", 64'(ifa.done), 1);
        chk("enc_count", 64'(ifa.count), 7);
        chk("enc_we_idle", 64'(ifa.imem_we), 0);

        // Illegal kinds
        start_a(1);
        chk("restart_done_clr", 64'(ifa.done), 0);
        send(4'd14, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 0, 0, 32'h0);
        idle_a();
        chk("ill_err", 64'(ifa.err), 1);
        chk("ill_no_we", 64'(ifa.imem_we), 0);
        chk("ill_count", 64'(ifa.count), 0);
        chk("ill_still_ready", 64'(ifa.in_ready), 1);
        send(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 0, 1, 32'h00853020);
        idle_a();
        chk("ill_err_sticky", 64'(ifa.err), 1);
        @(negedge clk);
        chk("ill_count1", 64'(ifa.count), 1);
        send(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1, 0, 32'h0);
        idle_a();
        chk("ill_last_done", 64'(ifa.done), 1);
        chk("ill_last_ready", 64'(ifa.in_ready), 0);
        start_a(1);
        chk("start_clr_err", 64'(ifa.err), 0);
        chk("start_clr_done", 64'(ifa.done), 0);

        // Two-descriptor session with in_last, then restart
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 0, 1, 32'h00221822);
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, 1, 32'h00221824);
        idle_a();
        @(negedge clk);
        chk("two_done", 64'(ifa.done), 1);
        chk("two_count", 64'(ifa.count), 2);
        chk("two_ready", 64'(ifa.in_ready), 0);
        start_a(1);
        chk("rs_done", 64'(ifa.done), 0);
        chk("rs_count", 64'(ifa.count), 0);
        chk("rs_ready", 64'(ifa.in_ready), 1);
        send(4'd3, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0, 0, 1, 32'h00642825);
        idle_a();
        start_a(0);
        chk("start_in_load_ign", 64'(ifa.count), 1);
        send(4'd4,  5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 0, 1, 32'h0022182A);
        send(4'd12, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'h0, 0, 1, 32'h342200FF);
        send(4'd6,  5'd0, 5'd3, 5'd0, 16'h8000, 26'h0, 1, 1, 32'h24038000);
        idle_a();
        @(negedge clk);
        chk("cont_count", 64'(ifa.count), 4);
        chk("cont_done", 64'(ifa.done), 1);

        // Capacity on the 4-word instance: six descriptors held valid, no in_last
        @(negedge clk);
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            ifb.in_kind  = 4'd0;
            ifb.in_rd    = 5'(i);
            ifb.in_valid = 1'b1;
            if (ifb.in_ready === 1'b1) begin
                e.addr = 10'(acc);
                e.w    = 32'h0000_0020 | (32'(i) << 11);
                e.cyc  = 0;
                qb.push_back(e);
                acc++;
            end
            @(negedge clk);
        end
        ifb.in_valid = 1'b0;
        chk("cap_accepts", 64'(acc), 4);
        chk("cap_ready", 64'(ifb.in_ready), 0);
        chk("cap_done", 64'(ifb.done), 1);
        chk("cap_count", 64'(ifb.count), 4);

        // Reset on the cycle after an accept
        start_a(1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 0, 1, 32'h00221820);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", 64'(ifa.imem_we), 0);
        chk("mid_rst_count", 64'(ifa.count), 0);
        chk("mid_rst_ready", 64'(ifa.in_ready), 0);
        chk("mid_rst_done", 64'(ifa.done), 0);
        reset = 1'b0;

        // Reset coinciding with an accept cancels the write
        start_a(1);
        ifa.in_kind  = 4'd0;
        ifa.in_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        ifa.in_valid = 1'b0;
        reset = 1'b0;
        chk("cancel_we", 64'(ifa.imem_we), 0);
        chk("cancel_ready", 64'(ifa.in_ready), 0);
        @(negedge clk);
        chk("cancel_we2", 64'(ifa.imem_we), 0);

        repeat (3) @(negedge clk);
        chk("qa_drained", 64'(qa.size()), 0);
        chk("qb_drained", 64'(qb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
